drum_div: RTL

- Sequential, dynamic-range, unbiased approximate signed divider. It is the inverse-direction companion of the DRUM approximate multiplier in the PE datapath.
- Uses the same signed-magnitude convention as the multiplier: one's-complement magnitude in, one's-complement result out.
- Truncates each operand to K significant bits with the LSB forced to 1, then runs a multi-cycle restoring division on the truncated values.
- Used for normalisation/scaling stages; valid/ready handshake on both sides.

---
 rtl/drum_div.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/drum_div.sv
// Multi-cycle DRUM-style approximate signed divider (one's-complement magnitudes).
// Define DRUM_DIV_ROUND_EN to round half up instead of truncating on right shifts.
module drum_div #(
    parameter int K = 6,
    parameter int N = 16,
    parameter int M = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [M-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] r,
    output logic         dbz
);

    localparam int LW = (N > M) ? N : M;
    localparam int SW = $clog2(LW + 1) + 1;
    localparam int CW = $clog2(2 * K) + 1;
    localparam int WS = N + M + 2 * K + 2;
    localparam int HW = $clog2(WS) + 1;
    localparam logic [N-1:0] QMAX = {1'b0, {(N - 1){1'b1}}};

    typedef enum logic [2:0] {S_IDLE, S_NORM, S_DIV, S_POST, S_DONE} state_t;

    state_t          state, state_nx;
    logic [N-1:0]    mag_a;
    logic [M-1:0]    mag_b;
    logic            sign;
    logic [K-1:0]    tb;
    logic [SW-1:0]   sa, sb;
    logic [2*K-1:0]  q;
    logic [K-1:0]    rem;
    logic [CW-1:0]   cnt;

    logic [K-1:0]    ta_c, tb_c;
    logic [SW-1:0]   sa_c, sb_c;
    logic [K:0]      rem_sh;
    logic [WS-1:0]   qw, shq;
    logic [N-1:0]    mag_q;
    int              la, lb, e;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (in_valid) state_nx = S_NORM;
            S_NORM: state_nx = (mag_b == '0) ? S_POST : S_DIV;
            S_DIV:  if (cnt == CW'(2 * K - 1)) state_nx = S_POST;
            S_POST: state_nx = S_DONE;
            S_DONE: if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Leading-one detect and K-bit truncation with the kept LSB forced to 1.
    always_comb begin
        la = 0;
        lb = 0;
        for (int i = 0; i < N; i++) if (mag_a[i]) la = i;
        for (int i = 0; i < M; i++) if (mag_b[i]) lb = i;
        if (la >= K) begin
            ta_c = K'(mag_a >> (la - K + 1)) | K'(1);
            sa_c = SW'(la - K + 1);
        end else begin
            ta_c = mag_a[K-1:0];
            sa_c = '0;
        end
        if (lb >= K) begin
            tb_c = K'(mag_b >> (lb - K + 1)) | K'(1);
            sb_c = SW'(lb - K + 1);
        end else begin
            tb_c = mag_b[K-1:0];
            sb_c = '0;
        end
    end

    assign rem_sh = {rem, q[2*K-1]};

    // Rescale the quotient by the truncation shifts; wide enough that the clamp sees real overflow.
    always_comb begin
        e   = int'(sa) - int'(sb) - K;
        qw  = WS'(q);
        shq = '0;
        if (e >= 0) begin
            shq = qw << HW'(e);
        end else begin
`ifdef DRUM_DIV_ROUND_EN
            qw  = qw + (WS'(1) << HW'(-e - 1));
`endif
            shq = qw >> HW'(-e);
        end
        if (dbz)                  mag_q = QMAX;
        else if (shq > WS'(QMAX)) mag_q = QMAX;
        else                      mag_q = shq[N-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mag_a <= '0;
            mag_b <= '0;
            sign  <= 1'b0;
            tb    <= '0;
            sa    <= '0;
            sb    <= '0;
            q     <= '0;
            rem   <= '0;
            cnt   <= '0;
            r     <= '0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    mag_a <= a[N-1] ? ~a : a;
                    mag_b <= b[M-1] ? ~b : b;
                    sign  <= a[N-1] ^ b[M-1];
                    dbz   <= 1'b0;
                end
                S_NORM: begin
                    q   <= {ta_c, {K{1'b0}}};
                    rem <= '0;
                    cnt <= '0;
                    tb  <= tb_c;
                    sa  <= sa_c;
                    sb  <= sb_c;
                    if (mag_b == '0) dbz <= 1'b1;
                end
                S_DIV: begin
                    if (rem_sh >= {1'b0, tb}) begin
                        rem <= K'(rem_sh - {1'b0, tb});
                        q   <= {q[2*K-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[K-1:0];
                        q   <= {q[2*K-2:0], 1'b0};
                    end
                    cnt <= cnt + CW'(1);
                end
                S_POST: r <= sign ? ~mag_q : mag_q;
                default: ;
            endcase
        end
    end

endmodule
